// File: rtl/min_sec_timer_core.sv
// Min:sec BCD timer core: 1 Hz prescaler, up/down count, run/pause/clear control.
// Build option SATURATE_UP_EN: up counting stops at 99:59 and enters DONE.
module min_sec_timer_core #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_toggle,
  input  logic       clear,
  input  logic       count_down,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       tick_1hz,
  output logic       blink
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    min_r;
  logic [7:0]    sec_r;
  logic          done_r;

  logic [4:0] su_s, st_s, mu_s;
  logic [4:0] du_s, dt_s, dmu_s;
  logic [7:0] up_min_s, up_sec_s, dn_min_s, dn_sec_s;
  logic [7:0] step_min_s, step_sec_s;
  logic       step_done_s;
  logic       up_stop_s;
  logic       tick_s;
  logic       at_zero_s;

  // Returns {carry, digit}: digit+1, wrapping to 0 past top.
  function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
  endfunction

  function automatic logic [3:0] digit_inc_nc(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? 4'd0 : d + 4'd1;
  endfunction

  // Returns {borrow, digit}: digit-1, wrapping to top below 0.
  function automatic logic [4:0] digit_dec(input logic [3:0] d, input logic [3:0] top);
    return (d == 4'd0) ? {1'b1, top} : {1'b0, d - 4'd1};
  endfunction

  function automatic logic [3:0] digit_dec_nb(input logic [3:0] d, input logic [3:0] top);
    return (d == 4'd0) ? top : d - 4'd1;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] sanitize_min(input logic [7:0] m);
    return {clamp_digit(m[7:4]), clamp_digit(m[3:0])};
  endfunction

  function automatic logic [7:0] sanitize_sec(input logic [7:0] s);
    logic [7:0] c;
    c = {clamp_digit(s[7:4]), clamp_digit(s[3:0])};
    return (c[7:4] > 4'd5) ? 8'h59 : c;
  endfunction

`ifdef SATURATE_UP_EN
  assign up_stop_s = (min_r == 8'h99) && (sec_r == 8'h59);
`else
  assign up_stop_s = 1'b0;
`endif

  assign tick_s    = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
  assign at_zero_s = (min_r == 8'h00) && (sec_r == 8'h00);

  // Next BCD value for one count step, digit by digit with carry/borrow
  always_comb begin
    step_min_s  = min_r;
    step_sec_s  = sec_r;
    step_done_s = 1'b0;
    su_s  = digit_inc(sec_r[3:0], 4'd9);
    st_s  = su_s[4] ? digit_inc(sec_r[7:4], 4'd5) : {1'b0, sec_r[7:4]};
    mu_s  = st_s[4] ? digit_inc(min_r[3:0], 4'd9) : {1'b0, min_r[3:0]};
    up_sec_s = {st_s[3:0], su_s[3:0]};
    up_min_s = {mu_s[4] ? digit_inc_nc(min_r[7:4], 4'd9) : min_r[7:4], mu_s[3:0]};
    du_s  = digit_dec(sec_r[3:0], 4'd9);
    dt_s  = du_s[4] ? digit_dec(sec_r[7:4], 4'd5) : {1'b0, sec_r[7:4]};
    dmu_s = dt_s[4] ? digit_dec(min_r[3:0], 4'd9) : {1'b0, min_r[3:0]};
    dn_sec_s = {dt_s[3:0], du_s[3:0]};
    dn_min_s = {dmu_s[4] ? digit_dec_nb(min_r[7:4], 4'd9) : min_r[7:4], dmu_s[3:0]};
    if (count_down) begin
      step_min_s  = dn_min_s;
      step_sec_s  = dn_sec_s;
      step_done_s = (dn_min_s == 8'h00) && (dn_sec_s == 8'h00);
    end else if (up_stop_s) begin
      step_min_s  = min_r;
      step_sec_s  = sec_r;
      step_done_s = 1'b1;
    end else begin
      step_min_s  = up_min_s;
      step_sec_s  = up_sec_s;
      step_done_s = 1'b0;
    end
  end

  // Control FSM, prescaler, stored BCD value and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      presc_r <= '0;
      min_r   <= 8'h00;
      sec_r   <= 8'h00;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (clear) begin
        state_r <= ST_IDLE;
        presc_r <= '0;
        min_r   <= count_down ? sanitize_min(preset_min) : 8'h00;
        sec_r   <= count_down ? sanitize_sec(preset_sec) : 8'h00;
      end else begin
        case (state_r)
          ST_IDLE: begin
            // Nothing to count down from 00:00, so a start request is refused
            if (run_toggle && !(count_down && at_zero_s)) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_RUN: begin
            if (tick_s) begin
              presc_r <= '0;
              min_r   <= step_min_s;
              sec_r   <= step_sec_s;
              if (step_done_s) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else if (run_toggle) begin
                state_r <= ST_PAUSE;
              end else begin
                state_r <= ST_RUN;
              end
            end else begin
              presc_r <= presc_r + PW'(1);
              state_r <= run_toggle ? ST_PAUSE : ST_RUN;
            end
          end
          ST_PAUSE: state_r <= run_toggle ? ST_RUN : ST_PAUSE;
          ST_DONE:  state_r <= ST_DONE;
          default:  state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign min_bcd  = min_r;
  assign sec_bcd  = sec_r;
  assign running  = (state_r == ST_RUN);
  assign done     = done_r;
  assign tick_1hz = tick_s;
  assign blink    = (state_r != ST_RUN) || (presc_r < PRESC_HALF);

endmodule

// File: tb/tb_min_sec_timer_core.sv
// Self-checking bench for min_sec_timer_core: directed scenarios plus random stimulus
// against a total-seconds reference model.
module tb_min_sec_timer_core;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run_toggle = 1'b0;
  logic       clear = 1'b0;
  logic       count_down = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, done, tick_1hz, blink;

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0 idle, 1 run, 2 pause, 3 done; value as total seconds
  int m_state, m_presc, m_total;
  bit m_done;

  min_sec_timer_core #(.TICK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .run_toggle(run_toggle), .clear(clear),
    .count_down(count_down), .preset_min(preset_min), .preset_sec(preset_sec),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .done(done),
    .tick_1hz(tick_1hz), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int san(input logic [7:0] b, input int lim);
    int t, u, v;
    t = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    u = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    v = t * 10 + u;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_total = 0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic rt, input logic clr, input logic cd,
                            input logic [7:0] pm, input logic [7:0] ps);
    m_done = 1'b0;
    if (clr) begin
      m_state = 0;
      m_presc = 0;
      m_total = cd ? san(pm, 99) * 60 + san(ps, 59) : 0;
    end else begin
      case (m_state)
        0: if (rt && !(cd && m_total == 0)) m_state = 1;
        1: begin
          if (m_presc == DIV - 1) begin
            m_presc = 0;
            if (cd) begin
              m_total = (m_total + 5999) % 6000;
              if (m_total == 0) begin m_state = 3; m_done = 1'b1; end
            end else if (m_total == 5999) begin
`ifdef SATURATE_UP_EN
              m_state = 3; m_done = 1'b1;
`else
              m_total = 0;
`endif
            end else begin
              m_total = m_total + 1;
            end
            if (m_state == 1 && rt) m_state = 2;
          end else begin
            m_presc = m_presc + 1;
            if (rt) m_state = 2;
          end
        end
        2: if (rt) m_state = 1;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("min", 32'(min_bcd), 32'(to_bcd(m_total / 60)));
    chk("sec", 32'(sec_bcd), 32'(to_bcd(m_total % 60)));
    chk("running", 32'(running), 32'(m_state == 1));
    chk("done", 32'(done), 32'(m_done));
    chk("tick", 32'(tick_1hz), 32'(m_state == 1 && m_presc == DIV - 1));
    chk("blink", 32'(blink), 32'(m_state != 1 || m_presc < DIV / 2));
  endtask

  task automatic cyc(input logic rt, input logic clr);
    run_toggle = rt;
    clear = clr;
    @(posedge clk);
    model_edge(rt, clr, count_down, preset_min, preset_sec);
    @(negedge clk);
    run_toggle = 1'b0;
    clear = 1'b0;
    check_all();
  endtask

  initial begin
    int ticks;
    int k;
    model_reset();
    #2;
    check_all();
    chk("rst_blink", 32'(blink), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0);

    // up mode: ten ticks in 100 cycles, then 00:59 -> 01:00
    count_down = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0);
      if (tick_1hz) ticks++;
    end
    chk("up_ticks", 32'(ticks), 32'd10);
    chk("up_sec10", 32'(sec_bcd), 32'h10);
    repeat (500) cyc(1'b0, 1'b0);
    chk("up_min01", 32'(min_bcd), 32'h01);
    chk("up_sec00", 32'(sec_bcd), 32'h00);

    // 99:59 boundary in up mode
    count_down = 1'b1; preset_min = 8'h99; preset_sec = 8'h59;
    cyc(1'b0, 1'b1);
    count_down = 1'b0;
    cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
`ifdef SATURATE_UP_EN
    chk("sat_min", 32'(min_bcd), 32'h99);
    chk("sat_done", 32'(done), 32'd1);
    chk("sat_run", 32'(running), 32'd0);
    cyc(1'b1, 1'b0);
    chk("sat_done_once", 32'(done), 32'd0);
`else
    chk("wrap_min", 32'(min_bcd), 32'h00);
    chk("wrap_sec", 32'(sec_bcd), 32'h00);
    chk("wrap_run", 32'(running), 32'd1);
`endif

    // down mode from 00:02 to DONE
    count_down = 1'b1; preset_min = 8'h00; preset_sec = 8'h02;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_sec0", 32'(sec_bcd), 32'h00);
    cyc(1'b0, 1'b0);
    chk("dn_done_1cyc", 32'(done), 32'd0);
    cyc(1'b1, 1'b0);
    repeat (15) cyc(1'b0, 1'b0);
    chk("dn_stuck", 32'(running), 32'd0);
    preset_min = 8'h01; preset_sec = 8'h00;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    chk("dn_0059", 32'({min_bcd, sec_bcd}), 32'h0059);

    // pause keeps the partial second
    count_down = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b0);
      if (tick_1hz) ticks++;
    end
    chk("pause_ticks", 32'(ticks), 32'd0);
    chk("pause_blink", 32'(blink), 32'd1);
    cyc(1'b1, 1'b0);
    k = 0;
    while (k < 20 && sec_bcd == 8'h00) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    chk("resume_cycles", 32'(k), 32'd5);

    // clear beats run_toggle, then async reset mid-run
    count_down = 1'b1; preset_min = 8'h12; preset_sec = 8'h34;
    cyc(1'b1, 1'b1);
    chk("clr_run", 32'(running), 32'd0);
    chk("clr_val", 32'({min_bcd, sec_bcd}), 32'h1234);
    cyc(1'b1, 1'b0);
    repeat (23) cyc(1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_val", 32'({min_bcd, sec_bcd}), 32'h0000);
    chk("arst_run", 32'(running), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // preset sanitising and refused start at 00:00
    count_down = 1'b1; preset_min = 8'hA3; preset_sec = 8'h75;
    cyc(1'b0, 1'b1);
    chk("san_min", 32'(min_bcd), 32'h93);
    chk("san_sec", 32'(sec_bcd), 32'h59);
    preset_min = 8'h00; preset_sec = 8'h00;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("zero_idle", 32'(running), 32'd0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) count_down = 1'($urandom_range(1));
      if ($urandom_range(29) == 0) begin
        preset_min = 8'($urandom);
        preset_sec = 8'($urandom);
      end
      cyc(1'($urandom_range(7) == 0), 1'($urandom_range(59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
